tile_draw_engine: RTL and testbench
===================================

# tile_draw_engine

Parametrised pixel-plotting engine that draws rectangular tiles from a ROWS x COLS grid into the VGA adapter's write port. It generalises the fixed four-square, 8x8 game-board drawer in four ways: configurable tile size, grid and spacing; a start/busy/done handshake; per-tile palette colours; and normal, flash, erase and clear-grid modes. It sits between the game control FSM, which issues draw requests, and the VGA adapter (x, y, colour, plot).

## Interface
- TILE_W, 8: tile width in pixels (power of two not required)
- TILE_H, 8: tile height in pixels
- COLS, 2: tiles per grid row
- ROWS, 2: tile rows in grid
- GAP, 0: blank pixels between adjacent tiles, both axes
- ORIGIN_X, 0 / ORIGIN_Y, 0: screen coordinate of tile 0's top-left pixel
- X_W, 8 / Y_W, 7: output coordinate widths (160x120 adapter)
- IDX_W, 2: tile_idx width; must satisfy 2^IDX_W >= COLS*ROWS
- PALETTE, {3'b011,3'b100,3'b010,3'b001}: 3 bits per tile, tile 0 in LSBs
- clock  in  1  system clock
- resetn  in  1  reset, synchronous, active-low
- start  in  1  request; sampled only while busy=0
- tile_idx  in  IDX_W  tile to draw, row-major (idx = row*COLS + col)
- mode  in  2  00 normal (palette colour), 01 flash (3'b111), 10 erase (3'b000), 11 clear whole grid (3'b000)
- x  out  X_W  pixel x
- y  out  Y_W  pixel y
- colour  out  3  pixel colour
- plot  out  1  write-enable to adapter; x/y/colour valid when 1
- busy  out  1  request in progress
- done  out  1  one-cycle pulse at completion
- err  out  1  one-cycle pulse: request rejected

## Operation
- States: IDLE, LOAD, DRAW, DONE.
- IDLE: when start=1, latch tile_idx and mode. If mode!=11 and tile_idx >= COLS*ROWS, pulse err next cycle and stay IDLE. Otherwise go to LOAD.
- LOAD (1 cycle): compute base_x = ORIGIN_X + col*(TILE_W+GAP) and base_y = ORIGIN_Y + row*(TILE_H+GAP), with col = idx % COLS and row = idx / COLS. Select the colour from the mode. Clear pixel counters px=0, py=0. In mode 11, idx starts at 0.
- DRAW: each cycle output x = base_x+px and y = base_y+py, with plot=1. Scan is raster order: px increments fastest, wrapping at TILE_W-1 and then incrementing py.
  - After pixel (TILE_W-1, TILE_H-1): modes 00/01/10 go to DONE.
  - Mode 11 instead increments idx and returns to LOAD until idx = COLS*ROWS-1 has been drawn, then goes to DONE.
- DONE (1 cycle): done=1, plot=0, then return to IDLE.
- busy=1 in LOAD, DRAW and DONE. start is ignored while busy=1, with no queueing.
- Arithmetic: compute in X_W+1 / Y_W+1 bits, then truncate to X_W / Y_W. The integrator guarantees the grid fits the screen; no clipping is performed.
- x, y and colour hold their last value when plot=0.
- Reset, including mid-draw: state IDLE; x=0, y=0, colour=0, plot=0, busy=0, done=0, err=0; latched request discarded.

## Timing
- start sampled at edge E0. LOAD occupies E0..E1, with busy=1 visible after E0. The first plot=1 pixel appears after E1.
- Single tile: exactly TILE_W*TILE_H consecutive plot cycles. done is high for the cycle after the last pixel. busy falls together with done's deassertion.
- Total single-tile latency from the start edge to the done cycle: TILE_W*TILE_H + 2 cycles.
- Mode 11: COLS*ROWS*(TILE_W*TILE_H + 1) + 1 cycles start-to-done. plot drops for one LOAD cycle between tiles.
- err: one cycle after the rejecting start edge; busy stays 0.
- A new start is accepted on the first IDLE cycle after DONE, so back-to-back requests leave a minimum 1-cycle gap between done and busy.

## Test plan
- Defaults, start with idx=3, mode 00: exactly 64 plots covering x 8..15, y 8..15 in raster order, colour 011; done is a single pulse after 66 cycles.
- idx=1, mode 01, then idx=1, mode 10: pixels x 8..15, y 0..7 with colour 111, then the same pixels with colour 000; each request produces 64 plots.
- GAP=2, COLS=3, ROWS=2, idx=5: first pixel (20,10), last pixel (27,17).
- Mode 11 with defaults: 256 plots over the region (0..15, 0..15), all colour 000; done arrives 261 cycles after start.
- Defaults with COLS=3, ROWS=1, idx=3: err pulses once, no plot occurs, busy stays 0. A start issued mid-draw is ignored and the pixel count is unchanged.
- resetn=0 asserted at the 20th pixel: next cycle all outputs are 0 and the state is IDLE. A following start draws the complete tile.

Source files
------------

// File: rtl/tile_draw_engine_if.sv
// Request/pixel bus between the game controller, the tile draw engine and the VGA adapter.
// master: the side issuing requests and consuming pixels; slave: the draw engine.
interface tile_draw_engine_if #(
   parameter int unsigned IDX_W = 2,
   parameter int unsigned X_W   = 8,
   parameter int unsigned Y_W   = 7
);
   logic             start;
   logic [IDX_W-1:0] tile_idx;
   logic [1:0]       mode;
   logic [X_W-1:0]   x;
   logic [Y_W-1:0]   y;
   logic [2:0]       colour;
   logic             plot;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output start, tile_idx, mode,
      input  x, y, colour, plot, busy, done, err
   );

   modport slave (
      input  start, tile_idx, mode,
      output x, y, colour, plot, busy, done, err
   );
endinterface

// File: rtl/tile_draw_engine.sv
// tile_draw_engine: raster-plots one tile of a ROWS x COLS grid (or the whole grid)
// into the VGA adapter write port, with start/busy/done/err handshake.
module tile_draw_engine #(
   parameter int unsigned TILE_W   = 8,
   parameter int unsigned TILE_H   = 8,
   parameter int unsigned COLS     = 2,
   parameter int unsigned ROWS     = 2,
   parameter int unsigned GAP      = 0,
   parameter int unsigned ORIGIN_X = 0,
   parameter int unsigned ORIGIN_Y = 0,
   parameter int unsigned X_W      = 8,
   parameter int unsigned Y_W      = 7,
   parameter int unsigned IDX_W    = 2,
   parameter logic [3*COLS*ROWS-1:0] PALETTE = {3'b011, 3'b100, 3'b010, 3'b001}
) (
   input logic               clock,
   input logic               resetn,
   tile_draw_engine_if.slave bus
);
   localparam int unsigned NTILES = COLS * ROWS;
   localparam int unsigned PX_W   = (TILE_W > 1) ? $clog2(TILE_W) : 1;
   localparam int unsigned PY_W   = (TILE_H > 1) ? $clog2(TILE_H) : 1;

   localparam logic [1:0] MODE_NORMAL = 2'b00;
   localparam logic [1:0] MODE_FLASH  = 2'b01;
   localparam logic [1:0] MODE_CLEAR  = 2'b11;

   typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

   state_t           state, state_next;
   logic [IDX_W-1:0] idx;
   logic [1:0]       mode_r;
   logic [X_W:0]     base_x, base_x_calc;
   logic [Y_W:0]     base_y, base_y_calc;
   logic [PX_W-1:0]  px;
   logic [PY_W-1:0]  py;
   logic [2:0]       colour_sel, colour_calc, pal_col;
   logic [X_W-1:0]   x_cur, x_hold;
   logic [Y_W-1:0]   y_cur, y_hold;
   logic [2:0]       colour_hold;
   logic             err_r;
   logic             reject, last_px, last_tile;
   int unsigned      col_i, row_i;

   // Request qualification and scan-position decodes.
   always_comb begin
      reject    = (bus.mode != MODE_CLEAR) && (32'(bus.tile_idx) >= NTILES);
      last_px   = (px == PX_W'(TILE_W - 1)) && (py == PY_W'(TILE_H - 1));
      last_tile = (mode_r != MODE_CLEAR) || (32'(idx) == NTILES - 1);
   end

   // Tile geometry and colour for the currently latched tile index.
   always_comb begin
      col_i       = 32'(idx) % COLS;
      row_i       = 32'(idx) / COLS;
      base_x_calc = (X_W+1)'(ORIGIN_X + col_i * (TILE_W + GAP));
      base_y_calc = (Y_W+1)'(ORIGIN_Y + row_i * (TILE_H + GAP));
      pal_col     = 3'(PALETTE >> (3 * 32'(idx)));
      case (mode_r)
         MODE_NORMAL: colour_calc = pal_col;
         MODE_FLASH:  colour_calc = '1;
         default:     colour_calc = '0;
      endcase
      x_cur = X_W'(base_x + (X_W+1)'(px));
      y_cur = Y_W'(base_y + (Y_W+1)'(py));
   end

   // State register.
   always_ff @(posedge clock) begin
      if (!resetn) state <= IDLE;
      else         state <= state_next;
   end

   // Next-state logic; clear-grid mode loops back through LOAD once per tile.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (bus.start && !reject) state_next = LOAD;
         LOAD: state_next = DRAW;
         DRAW: if (last_px) state_next = last_tile ? DONE : LOAD;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: request latch, tile base, pixel counters and held pixel outputs.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         idx         <= '0;
         mode_r      <= '0;
         base_x      <= '0;
         base_y      <= '0;
         px          <= '0;
         py          <= '0;
         colour_sel  <= '0;
         x_hold      <= '0;
         y_hold      <= '0;
         colour_hold <= '0;
         err_r       <= 1'b0;
      end else begin
         err_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (reject) begin
                     err_r <= 1'b1;
                  end else begin
                     idx    <= (bus.mode == MODE_CLEAR) ? '0 : bus.tile_idx;
                     mode_r <= bus.mode;
                  end
               end
            end
            LOAD: begin
               base_x     <= base_x_calc;
               base_y     <= base_y_calc;
               colour_sel <= colour_calc;
               px         <= '0;
               py         <= '0;
            end
            DRAW: begin
               x_hold      <= x_cur;
               y_hold      <= y_cur;
               colour_hold <= colour_sel;
               if (px == PX_W'(TILE_W - 1)) begin
                  px <= '0;
                  if (py == PY_W'(TILE_H - 1)) begin
                     py <= '0;
                     if (!last_tile) idx <= idx + IDX_W'(1);
                  end else begin
                     py <= py + PY_W'(1);
                  end
               end else begin
                  px <= px + PX_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs: live pixel while plotting, otherwise the last plotted pixel is held.
   always_comb begin
      bus.plot   = (state == DRAW);
      bus.busy   = (state != IDLE);
      bus.done   = (state == DONE);
      bus.err    = err_r;
      bus.x      = bus.plot ? x_cur : x_hold;
      bus.y      = bus.plot ? y_cur : y_hold;
      bus.colour = bus.plot ? colour_sel : colour_hold;
   end
endmodule

// File: tb/tb_tile_draw_engine.sv
// Bench for tile_draw_engine: table of single/clear-grid requests on the default
// configuration plus hand sequences for gap geometry, rejection and mid-draw reset.
module tb_tile_draw_engine;
   logic clock = 1'b0;
   logic resetn;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clock = ~clock;

   tile_draw_engine_if #(.IDX_W(2), .X_W(8), .Y_W(7)) b0 ();
   tile_draw_engine_if #(.IDX_W(3), .X_W(8), .Y_W(7)) b1 ();
   tile_draw_engine_if #(.IDX_W(2), .X_W(8), .Y_W(7)) b2 ();

   tile_draw_engine dut0 (.clock(clock), .resetn(resetn), .bus(b0));

   tile_draw_engine #(
      .COLS(3), .ROWS(2), .GAP(2), .IDX_W(3),
      .PALETTE({3'b101, 3'b110, 3'b011, 3'b100, 3'b010, 3'b001})
   ) dut1 (.clock(clock), .resetn(resetn), .bus(b1));

   tile_draw_engine #(
      .COLS(3), .ROWS(1), .IDX_W(2),
      .PALETTE({3'b100, 3'b010, 3'b001})
   ) dut2 (.clock(clock), .resetn(resetn), .bus(b2));

   typedef struct {
      logic [1:0] idx;
      logic [1:0] mode;
      int         inject;
      int         bx;
      int         by;
      logic [2:0] col;
      int         plots;
      int         lat;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One request on dut0; expected pixels come from the tile base in the vector
   // (or from the 2x2 grid layout for clear-grid mode).
   task automatic run0(input vec_t v, input string nm);
      int plots = 0, pix_bad = 0, done_cyc = 0, done_cnt = 0, err_cnt = 0;
      int n, t, bx, by, ex, ey;
      logic [2:0] ecol;
      b0.tile_idx = v.idx;
      b0.mode     = v.mode;
      b0.start    = 1'b1;
      tick();
      b0.start = 1'b0;
      check({nm, " busy_in_load"}, 32'(b0.busy), 32'd1);
      for (int c = 1; c < 400; c++) begin
         if (c == v.inject) begin
            b0.start    = 1'b1;
            b0.tile_idx = v.idx + 2'd1;
            b0.mode     = 2'b00;
         end else begin
            b0.start = 1'b0;
         end
         if (b0.plot) begin
            n = plots;
            if (v.mode == 2'b11) begin
               t = n / 64;
               bx = (t % 2) * 8;
               by = (t / 2) * 8;
               ecol = 3'b000;
            end else begin
               bx = v.bx;
               by = v.by;
               ecol = v.col;
            end
            ex = bx + (n % 64) % 8;
            ey = by + (n % 64) / 8;
            if (b0.x !== 8'(ex) || b0.y !== 7'(ey) || b0.colour !== ecol) begin
               if (pix_bad == 0)
                  $display("  %s first bad pixel #%0d: got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                           nm, n, b0.x, b0.y, b0.colour, ex, ey, ecol);
               pix_bad++;
            end
            plots++;
         end
         if (b0.done) begin
            done_cnt++;
            if (done_cyc == 0) done_cyc = c;
         end
         if (b0.err) err_cnt++;
         if (done_cyc != 0 && c == done_cyc + 1) begin
            check({nm, " busy_after_done"}, 32'(b0.busy), 32'd0);
            break;
         end
         tick();
      end
      b0.start = 1'b0;
      check({nm, " plot_count"}, 32'(plots), 32'(v.plots));
      check({nm, " bad_pixels"}, 32'(pix_bad), 32'd0);
      check({nm, " done_latency"}, 32'(done_cyc), 32'(v.lat));
      check({nm, " done_pulses"}, 32'(done_cnt), 32'd1);
      check({nm, " err_pulses"}, 32'(err_cnt), 32'd0);
   endtask

   initial begin
      int plots, fx, fy, lx, ly, busy_cnt, got_done;
      logic [2:0] fcol;

      vecs[0] = '{2'd3, 2'b00, 0,  8, 8, 3'b011, 64,  66};
      vecs[1] = '{2'd1, 2'b01, 0,  8, 0, 3'b111, 64,  66};
      vecs[2] = '{2'd1, 2'b10, 0,  8, 0, 3'b000, 64,  66};
      vecs[3] = '{2'd0, 2'b00, 20, 0, 0, 3'b001, 64,  66};
      vecs[4] = '{2'd2, 2'b00, 0,  0, 8, 3'b100, 64,  66};
      vecs[5] = '{2'd2, 2'b11, 0,  0, 0, 3'b000, 256, 261};

      resetn = 1'b0;
      b0.start = 1'b0; b0.tile_idx = '0; b0.mode = '0;
      b1.start = 1'b0; b1.tile_idx = '0; b1.mode = '0;
      b2.start = 1'b0; b2.tile_idx = '0; b2.mode = '0;
      repeat (3) tick();

      check("reset x",      32'(b0.x),      32'd0);
      check("reset y",      32'(b0.y),      32'd0);
      check("reset colour", 32'(b0.colour), 32'd0);
      check("reset plot",   32'(b0.plot),   32'd0);
      check("reset busy",   32'(b0.busy),   32'd0);
      check("reset done",   32'(b0.done),   32'd0);
      check("reset err",    32'(b0.err),    32'd0);
      resetn = 1'b1;
      tick();

      for (int unsigned i = 0; i < 6; i++) run0(vecs[i], $sformatf("vec%0d", i));

      // Gap geometry: COLS=3, ROWS=2, GAP=2, tile 5 sits at column 2, row 1.
      b1.tile_idx = 3'd5; b1.mode = 2'b00; b1.start = 1'b1;
      tick();
      b1.start = 1'b0;
      plots = 0; fx = -1; fy = -1; lx = -1; ly = -1; fcol = '0; got_done = 0;
      for (int c = 1; c < 200; c++) begin
         if (b1.plot) begin
            if (plots == 0) begin
               fx = int'(b1.x); fy = int'(b1.y); fcol = b1.colour;
            end
            lx = int'(b1.x); ly = int'(b1.y);
            plots++;
         end
         if (b1.done) begin
            got_done = 1;
            break;
         end
         tick();
      end
      check("gap first_x", 32'(fx), 32'd20);
      check("gap first_y", 32'(fy), 32'd10);
      check("gap last_x",  32'(lx), 32'd27);
      check("gap last_y",  32'(ly), 32'd17);
      check("gap colour",  32'(fcol), 32'd5);
      check("gap plots",   32'(plots), 32'd64);
      check("gap done",    32'(got_done), 32'd1);
      tick();

      // Out-of-range tile on a 3-tile grid is rejected.
      b2.tile_idx = 2'd3; b2.mode = 2'b00; b2.start = 1'b1;
      tick();
      b2.start = 1'b0;
      check("reject err_pulse", 32'(b2.err),  32'd1);
      check("reject busy",      32'(b2.busy), 32'd0);
      tick();
      check("reject err_clear", 32'(b2.err),  32'd0);
      plots = 0; busy_cnt = 0;
      for (int c = 0; c < 10; c++) begin
         if (b2.plot) plots++;
         if (b2.busy) busy_cnt++;
         tick();
      end
      check("reject plots", 32'(plots),    32'd0);
      check("reject busy_cycles", 32'(busy_cnt), 32'd0);

      // Reset while the 20th pixel is on the bus, then a full redraw.
      b0.tile_idx = 2'd3; b0.mode = 2'b00; b0.start = 1'b1;
      tick();
      b0.start = 1'b0;
      plots = 0;
      for (int c = 1; c < 100; c++) begin
         if (b0.plot) plots++;
         if (plots == 20) break;
         tick();
      end
      check("midreset reached_px20", 32'(plots), 32'd20);
      check("midreset px20_x", 32'(b0.x), 32'd11);
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      check("midreset x",      32'(b0.x),      32'd0);
      check("midreset y",      32'(b0.y),      32'd0);
      check("midreset colour", 32'(b0.colour), 32'd0);
      check("midreset plot",   32'(b0.plot),   32'd0);
      check("midreset busy",   32'(b0.busy),   32'd0);
      check("midreset done",   32'(b0.done),   32'd0);
      tick();
      check("midreset idle_busy", 32'(b0.busy), 32'd0);
      run0(vecs[0], "after_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
